instruction_fetch: RTL and testbench

//  Front-end fetch stage: owns the PC, issues in-order word reads to instruction memory, buffers

---
 rtl/instruction_fetch_pkg.sv | 35 +++
 rtl/instruction_fetch_fifo.sv | 67 ++++++
 rtl/instruction_fetch.sv | 128 ++++++++++++
 tb/tb_instruction_fetch.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared fetch/decode definitions: reset vector default, canonical NOP,
// RV32 base opcodes used by decode, and the fetch-buffer entry layout.
package instruction_fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR            = 32'h0000_0013;  // addi x0, x0, 0

  // Major opcodes (instr[6:0]) shared with the decode stage
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // One fetch-buffer entry: the word and the address it came from
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  localparam int unsigned ENTRY_W = $bits(fetch_entry_t);

  // Force a byte address onto a word boundary
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/instruction_fetch_fifo.sv
// fetch_fifo: synchronous FIFO holding fetched {pc, instr} entries.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   push, wdata   write request and data (ignored when full unless popping)
//   pop           read request (ignored when empty)
//   flush         empties the FIFO; a same-cycle push is discarded
//   rdata         head entry (valid when !empty)
//   full, empty   occupancy flags
//   count         number of stored entries
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  // A pop frees the slot a same-cycle push needs, so push-on-full is legal with pop
  assign do_pop  = pop && (cnt != '0);
  assign do_push = push && (!full || do_pop);

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign rdata = mem[rd_ptr];

  // Pointer and occupancy tracking
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage array, no reset needed: entries are only read once counted valid
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: front-end fetch stage. Owns the PC, issues in-order
// word reads to instruction memory under a credit scheme that guarantees a
// buffer slot for every response, buffers returned words with their PC and
// presents them to decode over valid/ready. Redirects flush the buffer and
// drop responses that were already in flight.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_req_o/addr_o        read request and word-aligned byte address
//   imem_gnt_i               memory accepts the request this cycle
//   imem_rvalid_i/rdata_i    in-order read response
//   redirect_i/redirect_pc_i taken branch/jump target from execute
//   instr_valid_o/ready_i    handshake to decode
//   instr_o, pc_o            fetched word and its address
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int unsigned FIFO_DEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW = CW + 1;

  logic [31:0]  pc;
  logic [31:0]  rsp_pc;       // address of the next non-discarded response
  logic [CW-1:0] in_flight;
  logic [CW-1:0] discard;

  logic          credit_ok;
  logic          issue;
  logic          rsp_accept;
  logic          discard_hit;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;

  // Credit: outstanding reads plus buffered words never exceed buffer depth
  assign credit_ok  = ((SW'(in_flight) + SW'(fifo_count)) < SW'(FIFO_DEPTH));
  assign imem_req_o = !rst && !redirect_i && credit_ok;
  assign imem_addr_o = pc;
  assign issue       = imem_req_o && imem_gnt_i;

  // Responses with nothing outstanding are a protocol error and are ignored
  assign rsp_accept  = imem_rvalid_i && (in_flight != '0);
  assign discard_hit = rsp_accept && (discard != '0);
  assign fifo_push   = rsp_accept && !redirect_i && (discard == '0);

  // A handshake in a redirect cycle is not a consumption; the flush wins
  assign fifo_pop = instr_valid_o && instr_ready_i && !redirect_i;

  assign push_entry.pc    = rsp_pc;
  assign push_entry.instr = imem_rdata_i;

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (push_entry),
    .pop   (fifo_pop),
    .flush (redirect_i),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Decode sees the buffer head; idle outputs park at NOP / reset vector
  assign instr_valid_o = !fifo_empty;
  assign instr_o       = fifo_empty ? NOP_INSTR    : head_entry.instr;
  assign pc_o          = fifo_empty ? RESET_VECTOR : head_entry.pc;

  // PC, response-PC, in-flight and discard bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_VECTOR;
      rsp_pc    <= RESET_VECTOR;
      in_flight <= '0;
      discard   <= '0;
    end else begin
      case ({issue, rsp_accept})
        2'b10:   in_flight <= in_flight + CW'(1);
        2'b01:   in_flight <= in_flight - CW'(1);
        default: in_flight <= in_flight;
      endcase

      if (redirect_i) begin
        // Everything still outstanding after this cycle belongs to the old path
        pc      <= word_align(redirect_pc_i);
        rsp_pc  <= word_align(redirect_pc_i);
        discard <= in_flight - (rsp_accept ? CW'(1) : CW'(0));
      end else begin
        if (issue)       pc      <= pc + 32'd4;
        if (fifo_push)   rsp_pc  <= rsp_pc + 32'd4;
        if (discard_hit) discard <= discard - CW'(1);
      end
    end
  end

  // Memory must not answer reads that were never issued
  a_rvalid_has_request : assert property (@(posedge clk) disable iff (rst)
    imem_rvalid_i |-> (in_flight != '0));

  // Credit scheme guarantees a free slot for every accepted response
  a_push_has_slot : assert property (@(posedge clk) disable iff (rst)
    fifo_push |-> (!fifo_full || fifo_pop));

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] pc_o;

  instruction_fetch #(
    .RESET_VECTOR (32'h0000_0000),
    .FIFO_DEPTH   (2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .pc_o          (pc_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pq[$];
  logic [31:0] cons_pc[$];
  logic [31:0] cons_instr[$];
  int          cons_cyc[$];
  int          cyc;
  int          lat;
  bit          gnt_toggle;
  int          hold_checks;
  int          hold_bad;
  bit          prev_stall;
  logic [31:0] prev_addr;
  int          checks;
  int          failures;

  // Memory model (data = ~addr, fixed latency) and decode-side recorder
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      pq.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        hold_checks = hold_checks + 1;
        if (imem_addr_o !== prev_addr) hold_bad = hold_bad + 1;
      end
      prev_stall = imem_req_o && !imem_gnt_i;
      prev_addr  = imem_addr_o;
      if (imem_req_o && imem_gnt_i) pq.push_back('{imem_addr_o, cyc + lat});
      if (instr_valid_o && instr_ready_i && !redirect_i) begin
        cons_pc.push_back(pc_o);
        cons_instr.push_back(instr_o);
        cons_cyc.push_back(cyc);
      end
    end
    #2;
    if (!rst && pq.size() > 0 && pq[0].due <= cyc + 1) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = ~pq[0].addr;
      void'(pq.pop_front());
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'h0;
    end
    imem_gnt_i = gnt_toggle ? ~imem_gnt_i : 1'b1;
  end

  function automatic logic [31:0] get_pc(input int idx);
    return (idx < cons_pc.size()) ? cons_pc[idx] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] get_instr(input int idx);
    return (idx < cons_instr.size()) ? cons_instr[idx] : 32'hxxxx_xxxx;
  endfunction

  function automatic int get_cyc(input int idx);
    return (idx < cons_cyc.size()) ? cons_cyc[idx] : -1000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    cons_pc.delete();
    cons_instr.delete();
    cons_cyc.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = 32'h0; instr_ready_i = 1'b1;
    lat = 1; gnt_toggle = 1'b0;
    repeat (3) tick();
    checks = checks + 5;
    if (imem_req_o !== 1'b0) begin failures++; $display("FAIL reset_req got %b want 0", imem_req_o); end
    if (instr_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got %b want 0", instr_valid_o); end
    if (instr_o !== NOP) begin failures++; $display("FAIL reset_instr got %h want %h", instr_o, NOP); end
    if (pc_o !== 32'h0) begin failures++; $display("FAIL reset_pc got %h want 0", pc_o); end
    if (imem_addr_o !== 32'h0) begin failures++; $display("FAIL reset_addr got %h want 0", imem_addr_o); end
  endtask

  task automatic test_stream();
    clear_log();
    rst = 1'b0;
    tick();
    checks = checks + 2;
    if (instr_valid_o !== 1'b0) begin failures++; $display("FAIL stream_fill_valid got %b want 0", instr_valid_o); end
    if (imem_addr_o !== 32'h4) begin failures++; $display("FAIL stream_addr got %h want 4", imem_addr_o); end
    tick();
    checks = checks + 3;
    if (instr_valid_o !== 1'b1) begin failures++; $display("FAIL stream_first_valid got %b want 1", instr_valid_o); end
    if (pc_o !== 32'h0) begin failures++; $display("FAIL stream_first_pc got %h want 0", pc_o); end
    if (instr_o !== 32'hFFFF_FFFF) begin failures++; $display("FAIL stream_first_instr got %h want ffffffff", instr_o); end
    repeat (12) tick();
    for (int i = 0; i < 4; i++) begin
      checks = checks + 2;
      if (get_pc(i) !== 32'(4 * i)) begin failures++; $display("FAIL stream_pc[%0d] got %h want %h", i, get_pc(i), 32'(4 * i)); end
      if (get_instr(i) !== ~32'(4 * i)) begin failures++; $display("FAIL stream_instr[%0d] got %h want %h", i, get_instr(i), ~32'(4 * i)); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    logic [31:0] last;
    int          n0;
    instr_ready_i = 1'b0;
    repeat (5) tick();
    held = pc_o;
    repeat (5) tick();
    n0   = cons_pc.size();
    last = get_pc(n0 - 1);
    checks = checks + 5;
    if (instr_valid_o !== 1'b1) begin failures++; $display("FAIL bp_valid got %b want 1", instr_valid_o); end
    if (imem_req_o !== 1'b0) begin failures++; $display("FAIL bp_req got %b want 0", imem_req_o); end
    if (pc_o !== held) begin failures++; $display("FAIL bp_stable_pc got %h want %h", pc_o, held); end
    if (instr_o !== ~held) begin failures++; $display("FAIL bp_stable_instr got %h want %h", instr_o, ~held); end
    if (held !== last + 32'd4) begin failures++; $display("FAIL bp_head_pc got %h want %h", held, last + 32'd4); end
    instr_ready_i = 1'b1;
    repeat (10) tick();
    checks = checks + 2;
    if (get_cyc(n0 + 1) - get_cyc(n0) != 1) begin failures++; $display("FAIL bp_two_buffered gap got %0d want 1", get_cyc(n0 + 1) - get_cyc(n0)); end
    if (get_cyc(n0 + 2) - get_cyc(n0 + 1) != 2) begin failures++; $display("FAIL bp_only_two gap got %0d want 2", get_cyc(n0 + 2) - get_cyc(n0 + 1)); end
    for (int k = 0; k < 4; k++) begin
      checks = checks + 1;
      if (get_pc(n0 + k) !== last + 32'(4 * (k + 1))) begin
        failures++; $display("FAIL bp_resume_pc[%0d] got %h want %h", k, get_pc(n0 + k), last + 32'(4 * (k + 1)));
      end
    end
  endtask

  task automatic test_gnt_toggle();
    int n0;
    int hc0;
    int hb0;
    n0  = cons_pc.size();
    hc0 = hold_checks;
    hb0 = hold_bad;
    gnt_toggle = 1'b1;
    repeat (20) tick();
    gnt_toggle = 1'b0;
    checks = checks + 3;
    if (!(hold_checks > hc0)) begin failures++; $display("FAIL gnt_stalls_seen got %0d want >%0d", hold_checks, hc0); end
    if (hold_bad !== hb0) begin failures++; $display("FAIL gnt_addr_hold got %0d changes want %0d", hold_bad - hb0, 0); end
    if (!(cons_pc.size() >= n0 + 4)) begin failures++; $display("FAIL gnt_progress got %0d words want >=4", cons_pc.size() - n0); end
    for (int k = 0; k < 4; k++) begin
      checks = checks + 1;
      if (get_pc(n0 + k) !== get_pc(n0 + k - 1) + 32'd4) begin
        failures++; $display("FAIL gnt_pc_step[%0d] got %h want %h", k, get_pc(n0 + k), get_pc(n0 + k - 1) + 32'd4);
      end
    end
  endtask

  task automatic test_redirect_inflight();
    rst = 1'b1; lat = 3;
    repeat (2) tick();
    clear_log();
    rst = 1'b0;
    tick();
    tick();
    checks = checks + 2;
    if (imem_req_o !== 1'b0) begin failures++; $display("FAIL rd_credit_req got %b want 0", imem_req_o); end
    if (imem_addr_o !== 32'h8) begin failures++; $display("FAIL rd_addr_before got %h want 8", imem_addr_o); end
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103;
    tick();
    redirect_i = 1'b0;
    checks = checks + 2;
    if (imem_addr_o !== 32'h0000_0100) begin failures++; $display("FAIL rd_new_addr got %h want 00000100", imem_addr_o); end
    if (instr_valid_o !== 1'b0) begin failures++; $display("FAIL rd_valid got %b want 0", instr_valid_o); end
    repeat (12) tick();
    checks = checks + 3;
    if (get_pc(0) !== 32'h0000_0100) begin failures++; $display("FAIL rd_first_pc got %h want 00000100", get_pc(0)); end
    if (get_instr(0) !== ~32'h0000_0100) begin failures++; $display("FAIL rd_first_instr got %h want %h", get_instr(0), ~32'h0000_0100); end
    if (get_pc(1) !== 32'h0000_0104) begin failures++; $display("FAIL rd_second_pc got %h want 00000104", get_pc(1)); end
  endtask

  task automatic test_redirect_collision();
    bit found;
    int n0;
    lat = 1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      #2;
      if (imem_rvalid_i === 1'b1 && instr_valid_o === 1'b1) found = 1'b1;
    end
    checks = checks + 1;
    if (found !== 1'b1) begin failures++; $display("FAIL col_setup got %b want 1", found); end
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0200;
    #1;
    checks = checks + 1;
    if (imem_req_o !== 1'b0) begin failures++; $display("FAIL col_req got %b want 0", imem_req_o); end
    n0 = cons_pc.size();
    tick();
    redirect_i = 1'b0;
    checks = checks + 1;
    if (instr_valid_o !== 1'b0) begin failures++; $display("FAIL col_valid got %b want 0", instr_valid_o); end
    repeat (10) tick();
    checks = checks + 2;
    if (get_pc(n0) !== 32'h0000_0200) begin failures++; $display("FAIL col_next_pc got %h want 00000200", get_pc(n0)); end
    if (get_pc(n0 + 1) !== 32'h0000_0204) begin failures++; $display("FAIL col_next2_pc got %h want 00000204", get_pc(n0 + 1)); end
  endtask

  task automatic test_wrap_and_reset();
    int n0;
    n0 = cons_pc.size();
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFF8;
    tick();
    redirect_i = 1'b0;
    repeat (12) tick();
    checks = checks + 4;
    if (get_pc(n0) !== 32'hFFFF_FFF8) begin failures++; $display("FAIL wrap_pc0 got %h want fffffff8", get_pc(n0)); end
    if (get_pc(n0 + 1) !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_pc1 got %h want fffffffc", get_pc(n0 + 1)); end
    if (get_pc(n0 + 2) !== 32'h0000_0000) begin failures++; $display("FAIL wrap_pc2 got %h want 00000000", get_pc(n0 + 2)); end
    if (get_instr(n0 + 2) !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_instr2 got %h want ffffffff", get_instr(n0 + 2)); end
    rst = 1'b1;
    tick();
    checks = checks + 5;
    if (imem_req_o !== 1'b0) begin failures++; $display("FAIL mid_rst_req got %b want 0", imem_req_o); end
    if (instr_valid_o !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got %b want 0", instr_valid_o); end
    if (pc_o !== 32'h0) begin failures++; $display("FAIL mid_rst_pc got %h want 0", pc_o); end
    if (instr_o !== NOP) begin failures++; $display("FAIL mid_rst_instr got %h want %h", instr_o, NOP); end
    if (imem_addr_o !== 32'h0) begin failures++; $display("FAIL mid_rst_addr got %h want 0", imem_addr_o); end
    clear_log();
    rst = 1'b0;
    tick();
    tick();
    checks = checks + 2;
    if (instr_valid_o !== 1'b1) begin failures++; $display("FAIL restart_valid got %b want 1", instr_valid_o); end
    if (pc_o !== 32'h0) begin failures++; $display("FAIL restart_pc got %h want 0", pc_o); end
    repeat (6) tick();
    checks = checks + 2;
    if (get_pc(0) !== 32'h0) begin failures++; $display("FAIL restart_seq0 got %h want 0", get_pc(0)); end
    if (get_pc(1) !== 32'h4) begin failures++; $display("FAIL restart_seq1 got %h want 4", get_pc(1)); end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1;
    imem_gnt_i = 1'b1; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    redirect_i = 1'b0; redirect_pc_i = 32'h0; instr_ready_i = 1'b1;
    cyc = 0; lat = 1; gnt_toggle = 1'b0;
    hold_checks = 0; hold_bad = 0; prev_stall = 1'b0; prev_addr = 32'h0;
    checks = 0; failures = 0;

    test_reset();
    test_stream();
    test_backpressure();
    test_gnt_toggle();
    test_redirect_inflight();
    test_redirect_collision();
    test_wrap_and_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no completion want completion");
    $fatal(1, "timeout");
  end

endmodule
